// File: rtl/mem_access_unit.sv
// Load/store front-end for the 1 KiB data memory: aligned word accesses,
// read-modify-write for sub-word stores, load extension and alignment checks.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_op,
    input  logic        req_unsigned,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_BYTE = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_WORD = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    state_t      state;
    logic        we_q;
    logic [1:0]  op_q;
    logic        uns_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        req_err;
    logic [31:0] merged;

    function automatic logic [31:0] extend_load(
        input logic [31:0] w,
        input logic [1:0]  op,
        input logic        uns,
        input logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (op)
            OP_BYTE: extend_load = {{24{b[7] & ~uns}}, b};
            OP_HALF: extend_load = {{16{h[15] & ~uns}}, h};
            default: extend_load = w;
        endcase
    endfunction

    always_comb begin
        req_err = (req_op == OP_ILL)
               || (req_op == OP_HALF && req_addr[0])
               || (req_op == OP_WORD && req_addr[1:0] != 2'b00);
    end

    // Sub-word store: replace only the target lane(s) of the word read back.
    always_comb begin
        merged = word_q;
        if (op_q == OP_BYTE)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // NOTE: dm_we and the handshake outputs are pure state decodes, so the
    // asynchronous reset drops them immediately and they cannot glitch on inputs.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) && err_q;
    assign dm_we      = (state == WRITE);
    assign dm_addr    = {addr_q[9:2], 2'b00};
    assign resp_rdata = rdata_q;

    always_comb begin
        dm_din = '0;
        if (state == WRITE)
            dm_din = (op_q == OP_WORD) ? wdata_q : merged;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            op_q    <= OP_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        op_q    <= req_op;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        if (req_err) begin
                            rdata_q <= '0;
                            state   <= DONE;
                        end else if (req_we && req_op == OP_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    word_q <= dm_dout;
                    if (we_q) begin
                        state <= WRITE;
                    end else begin
                        rdata_q <= extend_load(dm_dout, op_q, uns_q, addr_q[1:0]);
                        state   <= DONE;
                    end
                end
                WRITE: begin
                    rdata_q <= '0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a word-wide memory model sits behind
// the DUT, and a byte-level reference model predicts every response.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_op = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [256];
    logic [7:0]  ref_mem [1024];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_op      (req_op),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_we       (dm_we),
        .dm_dout     (dm_dout)
    );

    assign dm_dout = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_din;

    // Reference: byte-addressed little-endian memory with arithmetic extension.
    task automatic model(input logic we, input logic [1:0] op, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output int wr);
        int size;
        longint v;
        err = (op == 2'd3) || (op == 2'd1 && addr % 2 != 0) || (op == 2'd2 && addr % 4 != 0);
        rdata = 0;
        lat = 1;
        wr = 0;
        if (err) return;
        size = 1 << op;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
            lat = (size == 4) ? 2 : 3;
            wr = 1;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v + (longint'(ref_mem[int'(addr) + i]) << (8 * i));
            if (!uns && size < 4 && v[8*size-1]) v = v - (longint'(1) << (8 * size));
            rdata = v[31:0];
            lat = 2;
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [9:0] addr);
        int a;
        a = int'(addr) & ~3;
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    task automatic fail_int(input string name, input longint got, input longint exp);
        miscompares++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    task automatic run_req(input logic we, input logic [1:0] op, input logic uns,
                           input logic [9:0] addr, input logic [31:0] wdata,
                           input string name, output logic [31:0] got_rdata);
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        got_err;
        int          exp_lat, exp_wr, lat, wr_cnt;
        bit          ready_bad;
        bit          din_bad;
        model(we, op, uns, addr, wdata, exp_rdata, exp_err, exp_lat, exp_wr);
        got_rdata = '0;
        got_err = 1'b0;
        @(negedge clk);
        req_we = we; req_op = op; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        vectors++;
        if (req_ready !== 1'b1) fail_int({name, " ready_idle"}, req_ready, 1);
        @(posedge clk);
        lat = 0; wr_cnt = 0; ready_bad = 0; din_bad = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) req_valid = 1'b0;
            if (req_ready !== 1'b0) ready_bad = 1;
            if (dm_we === 1'b1) begin
                wr_cnt++;
                vectors++;
                if (dm_addr !== {addr[9:2], 2'b00}) fail_int({name, " dm_addr"}, dm_addr, {addr[9:2], 2'b00});
            end else if (dm_din !== 32'h0) din_bad = 1;
            if (resp_valid === 1'b1) begin
                lat = n;
                got_rdata = resp_rdata;
                got_err = resp_err;
            end
        end
        vectors += 6;
        if (lat != exp_lat) fail_int({name, " latency"}, lat, exp_lat);
        if (got_err !== exp_err) fail_int({name, " resp_err"}, got_err, exp_err);
        if (got_rdata !== exp_rdata) fail_int({name, " resp_rdata"}, got_rdata, exp_rdata);
        if (wr_cnt != exp_wr) fail_int({name, " dm_we_cycles"}, wr_cnt, exp_wr);
        if (ready_bad) fail_int({name, " ready_busy"}, 1, 0);
        if (din_bad) fail_int({name, " dm_din_idle"}, 1, 0);
        vectors++;
        if (mem[addr[9:2]] !== ref_word(addr)) fail_int({name, " mem_word"}, mem[addr[9:2]], ref_word(addr));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        vectors += 7;
        if (req_ready !== 1'b1) fail_int("reset req_ready", req_ready, 1);
        if (resp_valid !== 1'b0) fail_int("reset resp_valid", resp_valid, 0);
        if (resp_err !== 1'b0) fail_int("reset resp_err", resp_err, 0);
        if (resp_rdata !== 32'h0) fail_int("reset resp_rdata", resp_rdata, 0);
        if (dm_we !== 1'b0) fail_int("reset dm_we", dm_we, 0);
        if (dm_addr !== 10'h0) fail_int("reset dm_addr", dm_addr, 0);
        if (dm_din !== 32'h0) fail_int("reset dm_din", dm_din, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word();
        logic [31:0] r;
        run_req(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, "sw 0x010", r);
        run_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, "lw 0x010", r);
        vectors++;
        if (r !== 32'hDEADBEEF) fail_int("lw 0x010 const", r, 32'hDEADBEEF);
        run_req(1'b1, 2'd2, 1'b0, 10'h3FC, 32'hCAFEF00D, "sw 0x3FC", r);
        run_req(1'b0, 2'd2, 1'b1, 10'h3FC, 32'h0, "lw 0x3FC", r);
        vectors++;
        if (r !== 32'hCAFEF00D) fail_int("lw 0x3FC const", r, 32'hCAFEF00D);
    endtask

    task automatic test_byte_rmw();
        logic [31:0] r;
        run_req(1'b1, 2'd2, 1'b0, 10'h020, 32'h11223344, "sw 0x020", r);
        run_req(1'b1, 2'd0, 1'b0, 10'h022, 32'h555555AB, "sb 0x022", r);
        vectors++;
        if (mem[8] !== 32'h11AB3344) fail_int("sb rmw const", mem[8], 32'h11AB3344);
        run_req(1'b1, 2'd1, 1'b0, 10'h022, 32'h9999BEEF, "sh 0x022", r);
        vectors++;
        if (mem[8] !== 32'hBEEF3344) fail_int("sh rmw const", mem[8], 32'hBEEF3344);
    endtask

    task automatic test_load_ext();
        logic [31:0] r;
        run_req(1'b1, 2'd2, 1'b0, 10'h040, 32'h80FF7F01, "sw 0x040", r);
        run_req(1'b0, 2'd0, 1'b0, 10'h042, 32'h0, "lb 0x042", r);
        vectors++;
        if (r !== 32'hFFFFFFFF) fail_int("lb const", r, 32'hFFFFFFFF);
        run_req(1'b0, 2'd0, 1'b1, 10'h042, 32'h0, "lbu 0x042", r);
        vectors++;
        if (r !== 32'h000000FF) fail_int("lbu const", r, 32'h000000FF);
        run_req(1'b0, 2'd1, 1'b0, 10'h042, 32'h0, "lh 0x042", r);
        vectors++;
        if (r !== 32'hFFFF80FF) fail_int("lh const", r, 32'hFFFF80FF);
        run_req(1'b0, 2'd1, 1'b1, 10'h040, 32'h0, "lhu 0x040", r);
        vectors++;
        if (r !== 32'h00007F01) fail_int("lhu const", r, 32'h00007F01);
        run_req(1'b0, 2'd0, 1'b0, 10'h043, 32'h0, "lb 0x043", r);
    endtask

    task automatic test_misalign();
        logic [31:0] r;
        run_req(1'b1, 2'd1, 1'b0, 10'h031, 32'h12345678, "sh 0x031", r);
        run_req(1'b0, 2'd2, 1'b0, 10'h032, 32'h0, "lw 0x032", r);
        run_req(1'b1, 2'd3, 1'b0, 10'h030, 32'hFFFFFFFF, "op11 store", r);
        run_req(1'b0, 2'd3, 1'b0, 10'h040, 32'h0, "op11 load", r);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2;
        logic        er;
        int          l, w;
        logic        rdy [6];
        logic        rv [6];
        logic [31:0] rd [6];
        logic        exp_rdy [6] = '{0, 0, 1, 0, 0, 1};
        logic        exp_rv [6]  = '{0, 1, 0, 0, 1, 0};
        model(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, e1, er, l, w);
        model(1'b0, 2'd0, 1'b1, 10'h041, 32'h0, e2, er, l, w);
        @(negedge clk);
        req_we = 1'b0; req_op = 2'd2; req_unsigned = 1'b0; req_addr = 10'h010;
        req_valid = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                req_op = 2'd0; req_unsigned = 1'b1; req_addr = 10'h041;
            end
            if (n == 4) req_valid = 1'b0;
            rdy[n-1] = req_ready;
            rv[n-1] = resp_valid;
            rd[n-1] = resp_rdata;
        end
        for (int i = 0; i < 6; i++) begin
            vectors += 2;
            if (rdy[i] !== exp_rdy[i]) fail_int($sformatf("b2b req_ready cycle %0d", i + 1), rdy[i], exp_rdy[i]);
            if (rv[i] !== exp_rv[i]) fail_int($sformatf("b2b resp_valid cycle %0d", i + 1), rv[i], exp_rv[i]);
        end
        vectors += 2;
        if (rd[1] !== e1) fail_int("b2b first rdata", rd[1], e1);
        if (rd[4] !== e2) fail_int("b2b second rdata", rd[4], e2);
    endtask

    task automatic test_reset_mid_store();
        int we_cnt, rv_cnt;
        @(negedge clk);
        req_we = 1'b1; req_op = 2'd1; req_unsigned = 1'b0; req_addr = 10'h052;
        req_wdata = 32'h0000A5A5 ^ $urandom;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors += 2;
        if (dm_we !== 1'b0) fail_int("rst mid dm_we", dm_we, 0);
        if (req_ready !== 1'b1) fail_int("rst mid req_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        we_cnt = 0; rv_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (dm_we === 1'b1) we_cnt++;
            if (resp_valid === 1'b1) rv_cnt++;
        end
        vectors += 4;
        if (we_cnt != 0) fail_int("rst mid stray dm_we", we_cnt, 0);
        if (rv_cnt != 0) fail_int("rst mid stray resp_valid", rv_cnt, 0);
        if (req_ready !== 1'b1) fail_int("rst mid ready after", req_ready, 1);
        if (mem[20] !== ref_word(10'h050)) fail_int("rst mid mem word", mem[20], ref_word(10'h050));
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int i = 0; i < 200; i++) begin
            run_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    10'($urandom_range(0, 127)), $urandom, $sformatf("rand %0d", i), r);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*i + b] = mem[i][8*b +: 8];
        end
        test_reset();
        test_word();
        test_byte_rmw();
        test_load_ext();
        test_misalign();
        test_back_to_back();
        test_reset_mid_store();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
